// File: rtl/ad7352_pkg.sv
// ad7352_pkg: shared FSM/lane types and frame timing constants for the AD7352 receiver.
package ad7352_pkg;
   typedef enum logic [1:0] {IDLE, CONV, GAP} state_e;
   typedef enum logic [1:0] {LANE_VCAP, LANE_ICAP, LANE_VOUT, LANE_IOUT} lane_e;
   localparam int CONV_CYCLES    = 16;
   localparam int FIRST_BIT_EDGE = 2;
   localparam int LAST_BIT_EDGE  = 13;
   localparam int XFER_EDGE      = 14;
   localparam int SAMPLE_W       = 12;
   localparam int NUM_LANES      = 4;
endpackage

// File: rtl/ad7352_lane.sv
// ad7352_lane: one MSB-first serial lane shift register with a held output sample.
module ad7352_lane
   import ad7352_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                shift_en,
   input  logic                xfer,
   input  logic                sdata,
   output logic [SAMPLE_W-1:0] sample
);
   logic [SAMPLE_W-1:0] shift_q, shift_d, sample_q, sample_d;
   always_comb begin
      shift_d  = shift_en ? {shift_q[SAMPLE_W-2:0], sdata} : shift_q;
      sample_d = xfer ? shift_q : sample_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_q  <= '0;
         sample_q <= '0;
      end else begin
         shift_q  <= shift_d;
         sample_q <= sample_d;
      end
   end
   assign sample = sample_q;
endmodule

// File: rtl/ad7352_rx.sv
// ad7352_rx: frames AD7352 conversions and deserialises four 12-bit lanes.
// Optional leading-zero framing check built when AD7352_RX_FRAME_CHECK_EN is defined.
module ad7352_rx
   import ad7352_pkg::*;
#(
   parameter int FRAME_PERIOD = 20
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   output logic                ad_cs,
   input  logic [1:0]          ad_sdata_a,
   input  logic [1:0]          ad_sdata_b,
   output logic                sample_valid,
   output logic [SAMPLE_W-1:0] vcap,
   output logic [SAMPLE_W-1:0] icap,
   output logic [SAMPLE_W-1:0] vout,
   output logic [SAMPLE_W-1:0] iout,
   output logic                frame_err
);
   localparam int CNT_W = 16;
   // Counter value during edge k is k-1, so each edge constant is offset by one.
   localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_PERIOD - 1);
   localparam logic [CNT_W-1:0] SHIFT_FIRST = CNT_W'(FIRST_BIT_EDGE - 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(LAST_BIT_EDGE - 1);
   localparam logic [CNT_W-1:0] XFER_CNT    = CNT_W'(XFER_EDGE - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 arm_q, arm_d, ad_cs_q, ad_cs_d, valid_q, valid_d;
   logic                 shift_en, xfer;
   logic [NUM_LANES-1:0] lane_bit;
   logic [SAMPLE_W-1:0]  sample [NUM_LANES];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      arm_d   = 1'b1;
      unique case (state_q)
         IDLE: if (enable && arm_q) begin
            state_d = CONV;
            cnt_d   = '0;
         end
         CONV: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = cnt_q == CONV_LAST ? GAP : CONV;
         end
         GAP: begin
            cnt_d   = cnt_q == FRAME_LAST ? '0 : cnt_q + CNT_W'(1);
            state_d = cnt_q != FRAME_LAST ? GAP : enable ? CONV : IDLE;
         end
         default: state_d = IDLE;
      endcase
      ad_cs_d  = state_d != CONV;
      shift_en = state_q == CONV && cnt_q >= SHIFT_FIRST && cnt_q <= SHIFT_LAST;
      xfer     = state_q == CONV && cnt_q == XFER_CNT;
      valid_d  = xfer;
   end

   // arm_q delays the first conversion after reset so ad_cs is seen high first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         arm_q   <= 1'b0;
         ad_cs_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         arm_q   <= arm_d;
         ad_cs_q <= ad_cs_d;
         valid_q <= valid_d;
      end
   end

   assign lane_bit[LANE_VCAP] = ad_sdata_b[1];
   assign lane_bit[LANE_ICAP] = ad_sdata_b[0];
   assign lane_bit[LANE_VOUT] = ad_sdata_a[1];
   assign lane_bit[LANE_IOUT] = ad_sdata_a[0];

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      ad7352_lane u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .shift_en (shift_en),
         .xfer     (xfer),
         .sdata    (lane_bit[i]),
         .sample   (sample[i])
      );
   end

`ifdef AD7352_RX_FRAME_CHECK_EN
   logic frame_err_q, frame_err_d;
   always_comb frame_err_d = frame_err_q | (state_q == CONV && cnt_q == '0 && |lane_bit);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) frame_err_q <= 1'b0;
      else          frame_err_q <= frame_err_d;
   end
   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

   assign ad_cs        = ad_cs_q;
   assign sample_valid = valid_q;
   assign vcap         = sample[LANE_VCAP];
   assign icap         = sample[LANE_ICAP];
   assign vout         = sample[LANE_VOUT];
   assign iout         = sample[LANE_IOUT];
endmodule

// File: tb/tb_ad7352_rx.sv
// tb_ad7352_rx: randomized ADC lane model with a scoreboard checking ad7352_rx frames.
module tb_ad7352_rx;
   localparam int FP = 20;
`ifdef AD7352_RX_FRAME_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
   logic [1:0]  ad_sdata_a = '0, ad_sdata_b = '0;
   logic        ad_cs, sample_valid, frame_err;
   logic [11:0] vcap, icap, vout, iout;

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   logic [47:0] exp_q[$];
   logic [47:0] last = '0;
   int falls[$], vcyc[$];
   int nvalid = 0, low_run = 0;
   bit rst_flag = 1;

   logic [11:0] cur [4];
   logic [11:0] fr [4];
   logic [3:0]  lead = '0, lead_now = '0;
   bit incr = 0, rnd = 0;
   int fidx = 0;

   ad7352_rx #(.FRAME_PERIOD(FP)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .ad_cs        (ad_cs),
      .ad_sdata_a   (ad_sdata_a),
      .ad_sdata_b   (ad_sdata_b),
      .sample_valid (sample_valid),
      .vcap         (vcap),
      .icap         (icap),
      .vout         (vout),
      .iout         (iout),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ADC model: leading zero, then the frame's value MSB first, junk elsewhere.
   always @(negedge clk) begin
      logic [3:0] b;
      if (!ad_cs) begin
         if (fidx == 0) begin
            for (int i = 0; i < 4; i++) fr[i] = cur[i];
            lead_now = lead;
            lead = '0;
            exp_q.push_back({cur[0], cur[1], cur[2], cur[3]});
            for (int i = 0; i < 4; i++) cur[i] = rnd ? 12'($urandom) : incr ? cur[i] + 12'd1 : cur[i];
         end
         for (int i = 0; i < 4; i++)
            b[i] = fidx == 0 ? lead_now[i] : fidx <= 12 ? fr[i][12-fidx] : 1'($urandom);
         fidx++;
      end else begin
         fidx = 0;
         b = 4'($urandom);
      end
      ad_sdata_b = {b[0], b[1]};
      ad_sdata_a = {b[2], b[3]};
   end

   // Monitor: chip-select shape, valid timing, bus hold and scoreboard compare.
   always @(negedge clk) begin
      if (!reset_n) rst_flag = 1;
      if (ad_cs) begin
         if (low_run > 0 && !rst_flag) check("cs_low_len", 48'(low_run), 48'd16);
         low_run = 0;
      end else begin
         if (low_run == 0) begin
            rst_flag = 0;
            falls.push_back(cyc);
         end
         low_run++;
      end
      if (sample_valid || low_run == 15) check("valid_timing", 48'(sample_valid), 48'(low_run == 15));
      if (low_run == 8) check("bus_hold", {vcap, icap, vout, iout}, last);
      if (sample_valid) begin
         nvalid++;
         vcyc.push_back(cyc);
         if (exp_q.size() == 0) check("spurious_valid", 48'(sample_valid), 48'd0);
         else begin
            last = exp_q.pop_front();
            check("sample_set", {vcap, icap, vout, iout}, last);
         end
      end
   end

   task automatic wait_nvalid(input int target);
      for (int k = 0; k < 400 && nvalid < target; k++) @(posedge clk);
      check("valid_wait", 48'(nvalid >= target), 48'd1);
      #1;
   endtask

   task automatic wait_falls(input int target);
      for (int k = 0; k < 400 && falls.size() < target; k++) @(posedge clk);
      check("fall_wait", 48'(falls.size() >= target), 48'd1);
      #1;
   endtask

   task automatic one_frame();
      enable = 1'b1;
      wait_nvalid(nvalid + 1);
      enable = 1'b0;
      repeat (30) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int nv0, nf0, rel;
      for (int i = 0; i < 4; i++) cur[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_cs", 48'(ad_cs), 48'd1);
      check("rst_valid", 48'(sample_valid), 48'd0);
      check("rst_buses", {vcap, icap, vout, iout}, 48'd0);
      check("rst_err", 48'(frame_err), 48'd0);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      cur[0] = 12'hA05; cur[1] = 12'h200; cur[2] = 12'h050; cur[3] = 12'h3FF;
      one_frame();
      check("basic_idle_cs", 48'(ad_cs), 48'd1);

      for (int i = 0; i < 4; i++) cur[i] = 12'($urandom);
      incr = 1;
      nv0 = vcyc.size();
      nf0 = falls.size();
      enable = 1'b1;
      wait_nvalid(nvalid + 5);
      enable = 1'b0;
      incr = 0;
      repeat (30) @(posedge clk);
      #1;
      check("frames_b", 48'(falls.size() - nf0), 48'd5);
      if (vcyc.size() >= nv0 + 5 && falls.size() >= nf0 + 5)
         for (int i = 1; i < 5; i++) begin
            check("valid_spacing", 48'(vcyc[nv0+i] - vcyc[nv0+i-1]), 48'(FP));
            check("fall_spacing", 48'(falls[nf0+i] - falls[nf0+i-1]), 48'(FP));
         end

      nv0 = nvalid;
      nf0 = falls.size();
      for (int i = 0; i < 4; i++) cur[i] = 12'($urandom);
      enable = 1'b1;
      wait_falls(nf0 + 2);
      repeat (3) @(posedge clk);
      #1;
      enable = 1'b0;
      wait_nvalid(nv0 + 2);
      repeat (50) @(posedge clk);
      #1;
      check("drop_frames", 48'(falls.size() - nf0), 48'd2);
      check("drop_valids", 48'(nvalid - nv0), 48'd2);
      check("drop_cs_high", 48'(ad_cs), 48'd1);

      for (int i = 0; i < 4; i++) cur[i] = 12'h5A5;
      nf0 = falls.size();
      enable = 1'b1;
      wait_falls(nf0 + 1);
      repeat (7) @(posedge clk);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      last = '0;
      #1;
      check("mid_rst_cs", 48'(ad_cs), 48'd1);
      check("mid_rst_valid", 48'(sample_valid), 48'd0);
      check("mid_rst_buses", {vcap, icap, vout, iout}, 48'd0);
      nv0 = nvalid;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rel = cyc;
      nf0 = falls.size();
      wait_falls(nf0 + 1);
      if (falls.size() > nf0) check("release_gap_ok", 48'(falls[nf0] - rel >= 2), 48'd1);
      wait_nvalid(nv0 + 1);
      enable = 1'b0;
      repeat (30) @(posedge clk);
      #1;

      cur[0] = 12'hFFF; cur[1] = '0; cur[2] = '0; cur[3] = '0;
      one_frame();

      for (int i = 0; i < 4; i++) cur[i] = 12'($urandom);
      rnd = 1;
      enable = 1'b1;
      wait_nvalid(nvalid + 6);
      enable = 1'b0;
      rnd = 0;
      repeat (30) @(posedge clk);
      #1;
      check("err_clean", 48'(frame_err), 48'd0);

      for (int i = 0; i < 4; i++) cur[i] = 12'($urandom);
      lead = 4'b1000;
      one_frame();
      check("err_set", 48'(frame_err), 48'(EXP_ERR));
      for (int i = 0; i < 4; i++) cur[i] = 12'($urandom);
      one_frame();
      check("err_sticky", 48'(frame_err), 48'(EXP_ERR));

      check("queue_drained", 48'(exp_q.size()), 48'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
